// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer
// Pixel source feeding the VGA controller's rgb_8 input. Tracks the raster
// position from pixel_en / v_sync, stores the 10x20 playfield as 3-bit colour
// codes, and produces a registered RRRGGGBB colour two clocks after each
// raster position.
//
// Optional feature: define GRID_LINES_EN to draw grid lines (colour 8'h25) on
// the first row and column of every 16x16 board cell.

module tetris_board_renderer #(
    parameter int PIX_DIV  = 20,
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_en,
    input  logic       v_sync,
    input  logic       cell_we,
    input  logic [3:0] cell_x,
    input  logic [4:0] cell_y,
    input  logic [2:0] cell_color,
    input  logic       board_clr,
    output logic [7:0] rgb_8
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int NUM_COLS = 10;
    localparam int NUM_ROWS = 20;
    localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;
    localparam int CELL_PX  = 16;
    localparam int BOARD_W  = NUM_COLS * CELL_PX;
    localparam int BOARD_H  = NUM_ROWS * CELL_PX;
    localparam int BORDER_W = 4;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       X_MAX   = 10'(H_PIXELS - 1);
    localparam logic [8:0]       Y_MAX   = 9'(V_LINES - 1);

    localparam logic signed [10:0] BX0     = 11'(BOARD_X0);
    localparam logic signed [10:0] BY0     = 11'(BOARD_Y0);
    localparam logic signed [10:0] BW      = 11'(BOARD_W);
    localparam logic signed [10:0] BH      = 11'(BOARD_H);
    localparam logic signed [10:0] BRD     = 11'(BORDER_W);
    localparam logic signed [10:0] BW_BRD  = 11'(BOARD_W + BORDER_W);
    localparam logic signed [10:0] BH_BRD  = 11'(BOARD_H + BORDER_W);

    localparam logic [7:0] BORDER_RGB = 8'h92;
    localparam logic [7:0] BLACK_RGB  = 8'h00;
`ifdef GRID_LINES_EN
    localparam logic [7:0] GRID_RGB   = 8'h25;
`endif

    // ------------------------------------------------------------------
    // Raster tracking state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic [9:0]       x;
    logic [8:0]       y;
    logic             pixel_en_d;
    logic             v_sync_d;
    logic             pe_fall;
    logic             vs_rise;

    assign pe_fall = pixel_en_d & ~pixel_en;
    assign vs_rise = v_sync & ~v_sync_d;

    // Raster counters: div paces pixels, x walks a line, y walks a frame;
    // a v_sync rise overrides the line increment so frame start always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            x          <= '0;
            y          <= '0;
            pixel_en_d <= 1'b0;
            v_sync_d   <= 1'b0;
        end else begin
            pixel_en_d <= pixel_en;
            v_sync_d   <= v_sync;

            if (pe_fall) begin
                x   <= '0;
                div <= '0;
            end else if (pixel_en) begin
                if (div == DIV_MAX) begin
                    div <= '0;
                    if (x != X_MAX) begin
                        x <= x + 10'd1;
                    end
                end else begin
                    div <= div + DIV_W'(1);
                end
            end

            if (vs_rise) begin
                y <= '0;
            end else if (pe_fall && (y != Y_MAX)) begin
                y <= y + 9'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Region decode (combinational front of stage 1)
    // ------------------------------------------------------------------
    logic signed [10:0] rx;
    logic signed [10:0] ry;
    logic               in_board;
    logic               in_frame;
    logic               in_border;
    logic [3:0]         dec_col;
    logic [4:0]         dec_row;
    logic [7:0]         dec_idx;
`ifdef GRID_LINES_EN
    logic               on_grid;
`endif

    // Signed relative coordinates so that positions left of or above the
    // board come out negative and decode as outside.
    always_comb begin
        rx        = signed'({1'b0, x}) - BX0;
        ry        = signed'({2'b00, y}) - BY0;
        in_board  = (rx >= 11'sd0) && (rx < BW) && (ry >= 11'sd0) && (ry < BH);
        in_frame  = (rx >= -BRD) && (rx < BW_BRD) && (ry >= -BRD) && (ry < BH_BRD);
        in_border = in_frame && !in_board;
        dec_col   = rx[7:4];
        dec_row   = ry[8:4];
        dec_idx   = ({3'b000, dec_row} * 8'd10) + {4'b0000, dec_col};
`ifdef GRID_LINES_EN
        on_grid   = (rx[3:0] == 4'd0) || (ry[3:0] == 4'd0);
`endif
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic       s1_board;
    logic       s1_border;
    logic [7:0] s1_idx;
    logic       s1_pe;
`ifdef GRID_LINES_EN
    logic       s1_grid;
`endif

    // Capture the decoded region for the current position together with the
    // matching active-video flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_board  <= 1'b0;
            s1_border <= 1'b0;
            s1_idx    <= '0;
            s1_pe     <= 1'b0;
`ifdef GRID_LINES_EN
            s1_grid   <= 1'b0;
`endif
        end else begin
            s1_board  <= in_board;
            s1_border <= in_border;
            s1_idx    <= in_board ? dec_idx : 8'd0;
            s1_pe     <= pixel_en;
`ifdef GRID_LINES_EN
            s1_grid   <= on_grid;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Playfield storage
    // ------------------------------------------------------------------
    logic [2:0] cells [0:NUM_CELLS-1];
    logic       wr_valid;
    logic [7:0] wr_idx;

    // Out-of-range coordinates are rejected here so they never alias into
    // another cell's slot.
    always_comb begin
        wr_valid = cell_we && (cell_x <= 4'd9) && (cell_y <= 5'd19);
        wr_idx   = ({3'b000, cell_y} * 8'd10) + {4'b0000, cell_x};
    end

    // Cell array: clear (reset or board_clr) beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || board_clr) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                cells[i] <= 3'd0;
            end
        end else if (wr_valid) begin
            cells[wr_idx] <= cell_color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: cell read, palette and blanking
    // ------------------------------------------------------------------
    logic [2:0] rd_code;
    logic [7:0] pal_rgb;

    function automatic logic [7:0] palette(input logic [2:0] code);
        logic [7:0] c;
        case (code)
            3'd0:    c = 8'h00;
            3'd1:    c = 8'h1F;
            3'd2:    c = 8'hFC;
            3'd3:    c = 8'hA2;
            3'd4:    c = 8'h1C;
            3'd5:    c = 8'hE0;
            3'd6:    c = 8'h03;
            default: c = 8'hF0;
        endcase
        return c;
    endfunction

    // Array read happens before the write edge, so a same-cycle write shows
    // the old code.
    always_comb begin
        rd_code = 3'd0;
        if (s1_idx < 8'(NUM_CELLS)) begin
            rd_code = cells[s1_idx];
        end
        pal_rgb = palette(rd_code);
    end

    // Output register: blank when the delayed active flag is low, otherwise
    // pick board, border or background colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_8 <= BLACK_RGB;
        end else if (!s1_pe) begin
            rgb_8 <= BLACK_RGB;
        end else if (s1_board) begin
`ifdef GRID_LINES_EN
            rgb_8 <= s1_grid ? GRID_RGB : pal_rgb;
`else
            rgb_8 <= pal_rgb;
`endif
        end else if (s1_border) begin
            rgb_8 <= BORDER_RGB;
        end else begin
            rgb_8 <= BLACK_RGB;
        end
    end

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Self-checking bench for tetris_board_renderer. Expected colours are queued
// with the clock cycle they must appear on rgb_8 and compared by a monitor on
// the falling edge.

module tb_tetris_board_renderer;

    logic       clk;
    logic       rst;
    logic       pixel_en;
    logic       v_sync;
    logic       cell_we;
    logic [3:0] cell_x;
    logic [4:0] cell_y;
    logic [2:0] cell_color;
    logic       board_clr;
    logic [7:0] rgb_8;

`ifdef GRID_LINES_EN
    localparam logic [7:0] CELL00_RGB = 8'h25;
    localparam logic [7:0] GRID_EMPTY = 8'h25;
    localparam logic [7:0] GRID_A2    = 8'h25;
`else
    localparam logic [7:0] CELL00_RGB = 8'hE0;
    localparam logic [7:0] GRID_EMPTY = 8'h00;
    localparam logic [7:0] GRID_A2    = 8'hA2;
`endif

    typedef struct {
        int         due;
        logic [7:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        cyc;
    int        check_count;
    int        pass_count;

    tetris_board_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_en   (pixel_en),
        .v_sync     (v_sync),
        .cell_we    (cell_we),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_color (cell_color),
        .board_clr  (board_clr),
        .rgb_8      (rgb_8)
    );

    // 10 ns system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, bumped on each rising edge
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Scoreboard monitor: compare every queued entry in the cycle it is due
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            if (e.due == cyc) checkOutput(e.tag, {8'h00, rgb_8}, {8'h00, e.exp});
            else checkOutput({e.tag, "_missed"}, 16'(e.due), 16'(cyc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectAt(input int due, input logic [7:0] exp, input string tag);
        sb_entry_t e;
        e.due = due;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic writeCell(input logic [3:0] cx, input logic [4:0] cy, input logic [2:0] col);
        cell_we    = 1'b1;
        cell_x     = cx;
        cell_y     = cy;
        cell_color = col;
        tick();
        cell_we    = 1'b0;
    endtask

    task automatic frameStart();
        v_sync = 1'b1;
        tick();
        v_sync = 1'b0;
        tick();
    endtask

    task automatic linePulses(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_en = 1'b1;
            tick();
            pixel_en = 1'b0;
            tick();
        end
    endtask

    // Scan to (tx,ty): the colour of x-1 is due one clock after x reaches tx,
    // the colour of tx two clocks after. Optionally reset mid-line afterwards.
    task automatic applyStimulus(input int tx, input int ty, input logic [7:0] exp_prev,
                                 input logic [7:0] exp_cur, input string tag, input bit do_rst);
        int k;
        frameStart();
        linePulses(ty);
        pixel_en = 1'b1;
        repeat (20 * tx) tick();
        k = cyc;
        expectAt(k + 1, exp_prev, {tag, "_prev"});
        expectAt(k + 2, exp_cur, tag);
        repeat (3) tick();
        if (do_rst) begin
            rst = 1'b1;
            tick();
            expectAt(cyc, 8'h00, {tag, "_rst_rgb"});
            rst = 1'b0;
            checkOutput({tag, "_rst_x"}, {6'd0, dut.x}, 16'd0);
        end
        pixel_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic drainQueue();
        int budget;
        budget = 100;
        while (sb_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("drain", 16'(sb_q.size()), 16'd0);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst         = 1'b1;
        pixel_en    = 1'b0;
        v_sync      = 1'b0;
        cell_we     = 1'b0;
        cell_x      = '0;
        cell_y      = '0;
        cell_color  = '0;
        board_clr   = 1'b0;

        // Reset state
        tick();
        expectAt(cyc, 8'h00, "reset_rgb");
        tick();
        rst = 1'b0;
        checkOutput("reset_x", {6'd0, dut.x}, 16'd0);
        checkOutput("reset_y", {7'd0, dut.y}, 16'd0);

        // One full pixel slot at x=0 (background), then line end
        pixel_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            expectAt(cyc + 2, 8'h00, "first_slot_rgb");
        end
        checkOutput("first_slot_x", {6'd0, dut.x}, 16'd1);
        pixel_en = 1'b0;
        tick();
        checkOutput("line_end_x", {6'd0, dut.x}, 16'd0);
        checkOutput("line_end_y", {7'd0, dut.y}, 16'd1);
        drainQueue();

        // Cell colour, borders, corner cell
        writeCell(4'd0, 5'd0, 3'd5);
        applyStimulus(240, 80, 8'h92, CELL00_RGB, "cell00_red", 1'b0);
        applyStimulus(238, 100, 8'h92, 8'h92, "left_border", 1'b0);
        applyStimulus(400, 100, 8'h00, 8'h92, "right_border", 1'b0);
        writeCell(4'd9, 5'd19, 3'd7);
        applyStimulus(399, 399, 8'hF0, 8'hF0, "cell919_orange", 1'b0);

        // Out-of-range writes must not land anywhere
        writeCell(4'd10, 5'd3, 3'd6);
        writeCell(4'd2, 5'd20, 3'd6);
        applyStimulus(241, 145, GRID_EMPTY, 8'h00, "oob_alias04", 1'b0);
        applyStimulus(273, 385, GRID_EMPTY, 8'h00, "oob_cell219", 1'b0);
        applyStimulus(241, 115, GRID_EMPTY, 8'h00, "oob_cell02", 1'b0);

        // Clear beats a simultaneous write, then a plain write lands
        cell_we    = 1'b1;
        cell_x     = 4'd0;
        cell_y     = 5'd0;
        cell_color = 3'd3;
        board_clr  = 1'b1;
        tick();
        cell_we    = 1'b0;
        board_clr  = 1'b0;
        applyStimulus(241, 81, GRID_EMPTY, 8'h00, "clr_priority", 1'b0);
        applyStimulus(399, 399, 8'h00, 8'h00, "clr_cell919", 1'b0);
        writeCell(4'd0, 5'd0, 3'd3);
        applyStimulus(241, 81, GRID_A2, 8'hA2, "write_purple", 1'b0);

        // Coincident line end and frame start at the last line, then saturation
        frameStart();
        linePulses(479);
        checkOutput("y_at_479", {7'd0, dut.y}, 16'd479);
        pixel_en = 1'b1;
        repeat (25) tick();
        checkOutput("x_before_coincide", {6'd0, dut.x}, 16'd1);
        pixel_en = 1'b0;
        v_sync   = 1'b1;
        tick();
        checkOutput("coincide_x", {6'd0, dut.x}, 16'd0);
        checkOutput("coincide_y", {7'd0, dut.y}, 16'd0);
        v_sync = 1'b0;
        tick();
        linePulses(481);
        checkOutput("y_saturate", {7'd0, dut.y}, 16'd479);

        // Reset mid-line blanks output and clears the board
        applyStimulus(241, 81, GRID_A2, 8'hA2, "pre_reset", 1'b1);
        applyStimulus(241, 81, GRID_EMPTY, 8'h00, "post_reset_cleared", 1'b0);

        drainQueue();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/tetris_board_renderer.md
# tetris_board_renderer

Pixel source that sits directly upstream of the VGA controller. It tracks the raster position from the controller's `pixel_en` and `v_sync` outputs and holds the 10×20 Tetris playfield as 3-bit colour codes written by game logic. For each on-screen pixel it produces the 8-bit RRRGGGBB colour that the controller consumes on its `rgb_8` input.

## Interface
- `PIX_DIV`, 20: clocks per pixel while `pixel_en` is high.
- `H_PIXELS`, 640: visible pixels per line.
- `V_LINES`, 480: visible lines per frame.
- `BOARD_X0`, 240: left pixel column of the playfield. Must be ≥4.
- `BOARD_Y0`, 80: top line of the playfield. Must be ≥4.

Ports:
- `clk`  in  1  system clock, the same clock as the VGA controller.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_en`  in  1  active-video flag from the VGA controller.
- `v_sync`  in  1  vertical sync from the VGA controller. Its rising edge marks frame start.
- `cell_we`  in  1  playfield write strobe.
- `cell_x`  in  4  playfield column, 0..9.
- `cell_y`  in  5  playfield row, 0..19 (row 0 at top).
- `cell_color`  in  3  colour code to write.
- `board_clr`  in  1  clears all 200 cells in one cycle.
- `rgb_8`  out  8  pixel colour to the VGA controller, RRRGGGBB.

## Operation
- **Raster tracking**
  - `div` (0..PIX_DIV-1) counts clocks while `pixel_en`=1.
  - When `div` wraps, `x` increments, saturating at H_PIXELS-1.
  - Falling edge of `pixel_en` (registered copy =1, current =0):
    - `x` and `div` are set to 0.
    - `y` increments, saturating at V_LINES-1.
  - Rising edge of `v_sync`: `y` is set to 0.
  - If a `v_sync` rise coincides with a `pixel_en` fall: `x`=0 and `y`=0 (v_sync wins on `y`).
- **Region decode**, in pipeline stage 1:
  - Relative coordinates: `rx`=x-BOARD_X0, `ry`=y-BOARD_Y0.
  - Board region: 0≤rx<160 and 0≤ry<320. Cell column = rx>>4, cell row = ry>>4.
  - Border region: the 4-pixel frame surrounding the board.
  - Everything else is background.
- **Playfield storage**
  - 200 × 3-bit register array.
  - `cell_we` writes `cell_color` to (`cell_x`,`cell_y`) at the clock edge.
  - Writes with `cell_x`>9 or `cell_y`>19 are ignored.
  - `board_clr` zeroes every cell and takes priority over a same-cycle `cell_we`.
  - A read of the cell being written in the same cycle returns the old value.
- **Palette**, in pipeline stage 2:
  - Codes: 0→8'h00, 1→8'h1F (cyan), 2→8'hFC (yellow), 3→8'hA2 (purple), 4→8'h1C (green), 5→8'hE0 (red), 6→8'h03 (blue), 7→8'hF0 (orange).
  - Border → 8'h92. Background → 8'h00.
- **Blanking**: `rgb_8` is forced to 8'h00 whenever the `pixel_en` value delayed through the pipeline is 0.

## Timing
- Reset, synchronous:
  - `x`, `y`, `div`, edge registers and pipeline registers are cleared.
  - All cells are cleared.
  - `rgb_8`=8'h00 in the cycle after `rst` is sampled high.
  - Reset mid-line: the raster restarts at (0,0). Realignment occurs on the next `v_sync` rise.
- Latency: 2 clocks from a raster position (`x`,`y`) to `rgb_8`. `rgb_8` is registered.
  - `rgb_8` therefore holds each pixel's colour for PIX_DIV-2 clocks inside the pixel slot.
  - The first 2 clocks of a pixel slot show the previous pixel.
- Cell writes take effect on the frame scan that follows the write edge. No handshake: one write per asserted clock.
- Raster counter arithmetic:
  - `x` is 10 bits and `y` is 9 bits, both unsigned.
  - `rx` and `ry` are computed 11-bit signed, so positions left of or above the board decode as outside.

## Configuration
- `GRID_LINES_EN` defined:
  - Board pixels with rx[3:0]==0 or ry[3:0]==0 output 8'h25 (grid colour), regardless of cell code.
  - Border and background are unchanged.
- `GRID_LINES_EN` undefined:
  - No grid; every board pixel shows its cell's palette colour.
  - No grid comparison logic is present.

## Test plan
- Reset, then a 20-clock `pixel_en` pulse → `x`=1 after the wrap, `rgb_8`=8'h00 throughout (x=0 is background).
- Write code 5 to cell (0,0), then scan to x=240, y=80 → 2 clocks after the position is reached, `rgb_8`=8'hE0 (8'h25 when `GRID_LINES_EN` is defined).
- Scan to x=238, y=100 → 8'h92 (border). Scan to x=400, y=100 → 8'h92 (right border, board spans x=240..399).
- Write to (10,3) and (2,20), then scan both positions → cells read back 0, `rgb_8`=8'h00.
- Assert `cell_we` (code 3, cell (0,0)) and `board_clr` in the same cycle → (0,0) reads 0. Write-then-scan in the following cycle → 8'hA2.
- Drive `pixel_en` fall and `v_sync` rise on the same clock at y=479 → `y`=0 and `x`=0. Then 481 line pulses → `y` saturates at 479.
